// File: rtl/ram_bus_arbiter.sv
// Two-requester (instruction fetch / data LSU) arbiter onto a single-port RAM with
// 1-cycle read latency, window-based error responses and a fetch-streak starvation guard.
module ram_bus_arbiter #(
  parameter int unsigned MEM_SIZE         = 65536,
  parameter logic [31:0] MEM_START        = 32'h0000_0000,
  parameter int unsigned MAX_INSTR_STREAK = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,

  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic        instr_err,
  output logic [31:0] instr_rdata,

  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic        data_err,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_MASK  = ~(32'(MEM_SIZE) - 32'd1);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_INSTR_STREAK);

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_INSTR = 2'd1,
    SRC_DATA  = 2'd2
  } src_e;

  src_e       src_q, src_d;
  logic       err_q, err_d;
  logic [3:0] streak_q, streak_d;

  logic grant_instr, grant_data;
  logic instr_in_win, data_in_win;

  assign instr_in_win = ((instr_addr & ADDR_MASK) == MEM_START);
  assign data_in_win  = ((data_addr  & ADDR_MASK) == MEM_START);

  // Grants are gated by reset so every output reads 0 while rst_sys_n is low.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (rst_sys_n) begin
      if (instr_req && !(data_req && (streak_q == STREAK_MAX))) begin
        grant_instr = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  assign instr_gnt = grant_instr;
  assign data_gnt  = grant_data;

  always_comb begin
    streak_d = streak_q;
    if (!data_req || grant_data) begin
      streak_d = '0;
    end else if (grant_instr && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_instr && instr_in_win) begin
      mem_req  = 1'b1;
      mem_be   = '1;
      mem_addr = instr_addr;
    end else if (grant_data && data_in_win) begin
      mem_req   = 1'b1;
      mem_write = data_we;
      mem_be    = data_be;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  always_comb begin
    src_d = SRC_NONE;
    err_d = 1'b0;
    if (grant_instr) begin
      src_d = SRC_INSTR;
      err_d = !instr_in_win;
    end else if (grant_data) begin
      src_d = SRC_DATA;
      err_d = !data_in_win;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      src_q    <= SRC_NONE;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      src_q    <= src_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign instr_rvalid = (src_q == SRC_INSTR);
  assign instr_err    = instr_rvalid && err_q;
  assign instr_rdata  = (instr_rvalid && !err_q) ? mem_rdata : '0;

  assign data_rvalid  = (src_q == SRC_DATA);
  assign data_err     = data_rvalid && err_q;
  assign data_rdata   = (data_rvalid && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized + directed bench for ram_bus_arbiter with a behavioural RAM and a
// transaction-level reference model checked every cycle on the falling clock edge.
module tb_ram_bus_arbiter;

  localparam int unsigned MEM_SIZE  = 65536;
  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam int          MAX_STRK  = 4;
  localparam int          WORDS     = MEM_SIZE / 4;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  ram_bus_arbiter #(
    .MEM_SIZE(MEM_SIZE),
    .MEM_START(MEM_START),
    .MAX_INSTR_STREAK(MAX_STRK)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_err(instr_err), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_err(data_err), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port RAM driven by the DUT's mem_* outputs.
  logic [31:0] ram [0:WORDS-1];
  logic [31:0] mm  [0:WORDS-1];

  always @(posedge clk_sys) begin
    if (mem_req) begin
      mem_rdata <= ram[mem_addr[15:2]];
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: predicted grants/RAM strobes for this cycle and the response
  // owed next cycle.
  int          streak_m;
  bit          pend_v, pend_i, pend_err, pend_chkr;
  logic [31:0] pend_rd;
  bit          wi, wd, iw, dw, e_irv, e_drv, e_mreq, e_mwr;
  logic [3:0]  e_mbe;
  logic [31:0] e_maddr, e_mwd;

  always @(negedge clk_sys) begin
    if (!rst_sys_n) begin
      chk("rst_ctl", 32'({instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid,
                          data_err, mem_req, mem_write, mem_be}), 32'd0);
      chk("rst_buses", instr_rdata | data_rdata | mem_addr | mem_wdata, 32'd0);
      streak_m = 0;
      pend_v   = 0;
    end else begin
      e_irv = pend_v && pend_i;
      e_drv = pend_v && !pend_i;
      chk("instr_rvalid", 32'(instr_rvalid), 32'(e_irv));
      chk("instr_err", 32'(instr_err), 32'(e_irv && pend_err));
      chk("instr_rdata", instr_rdata, (e_irv && !pend_err) ? pend_rd : 32'd0);
      chk("data_rvalid", 32'(data_rvalid), 32'(e_drv));
      chk("data_err", 32'(data_err), 32'(e_drv && pend_err));
      if (!(e_drv && !pend_err && !pend_chkr))
        chk("data_rdata", data_rdata, (e_drv && !pend_err) ? pend_rd : 32'd0);

      wi = instr_req && !(data_req && streak_m >= MAX_STRK);
      wd = data_req && !wi;
      chk("instr_gnt", 32'(instr_gnt), 32'(wi));
      chk("data_gnt", 32'(data_gnt), 32'(wd));

      iw = (instr_addr - MEM_START) < MEM_SIZE;
      dw = (data_addr - MEM_START) < MEM_SIZE;
      {e_mreq, e_mwr, e_mbe, e_maddr, e_mwd} = '0;
      if (wi && iw) {e_mreq, e_mwr, e_mbe, e_maddr, e_mwd} = {1'b1, 1'b0, 4'hF, instr_addr, 32'd0};
      if (wd && dw) {e_mreq, e_mwr, e_mbe, e_maddr, e_mwd} = {1'b1, data_we, data_be, data_addr, data_wdata};
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      chk("mem_write", 32'(mem_write), 32'(e_mwr));
      chk("mem_be", 32'(mem_be), 32'(e_mbe));
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_wdata", mem_wdata, e_mwd);

      pend_v    = wi || wd;
      pend_i    = wi;
      pend_err  = wi ? !iw : !dw;
      pend_chkr = wi || !data_we;
      if (wi && iw) pend_rd = mm[instr_addr[15:2]];
      if (wd && dw) begin
        pend_rd = mm[data_addr[15:2]];
        if (data_we)
          for (int b = 0; b < 4; b++)
            if (data_be[b]) mm[data_addr[15:2]][8*b +: 8] = data_wdata[8*b +: 8];
      end
      streak_m = (data_req && wi) ? ((streak_m < MAX_STRK) ? streak_m + 1 : MAX_STRK) : 0;
    end
  end

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  bit ig, dg;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
      mm[i]  = ram[i];
    end
    ram[4]  = 32'h0040_0093; mm[4]  = 32'h0040_0093;
    ram[64] = 32'h1234_5678; mm[64] = 32'h1234_5678;

    rst_sys_n  = 1'b0;
    instr_req  = 1'b1; instr_addr = 32'h10;
    data_req   = 1'b0; data_we = 1'b0; data_be = 4'h0;
    data_addr  = '0;   data_wdata = '0;

    // Reset held 10 cycles with a pending fetch.
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("lit_rst_gnt", 32'(instr_gnt), 32'd0);
    repeat (5) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    @(negedge clk_sys);
    chk("lit_fetch_gnt", 32'(instr_gnt), 32'd1);
    chk("lit_fetch_mreq", 32'(mem_req), 32'd1);
    chk("lit_fetch_maddr", mem_addr, 32'h10);
    chk("lit_fetch_mbe", 32'(mem_be), 32'hF);
    step(); instr_req = 1'b0;
    @(negedge clk_sys);
    chk("lit_fetch_rvalid", 32'(instr_rvalid), 32'd1);
    chk("lit_fetch_rdata", instr_rdata, 32'h0040_0093);
    chk("lit_fetch_err", 32'(instr_err), 32'd0);

    // Partial write.
    step();
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk_sys);
    chk("lit_wr_gnt", 32'(data_gnt), 32'd1);
    chk("lit_wr_mwrite", 32'(mem_write), 32'd1);
    step(); data_req = 1'b0; data_we = 1'b0;
    chk("lit_wr_ram", ram[64], 32'h1234_BEEF);
    @(negedge clk_sys);
    chk("lit_wr_rvalid", 32'(data_rvalid), 32'd1);

    // Out-of-window read.
    step(); data_req = 1'b1; data_addr = 32'h0001_0000; data_be = 4'hF;
    @(negedge clk_sys);
    chk("lit_oow_gnt", 32'(data_gnt), 32'd1);
    chk("lit_oow_mreq", 32'(mem_req), 32'd0);
    step(); data_req = 1'b0;
    @(negedge clk_sys);
    chk("lit_oow_rvalid", 32'(data_rvalid), 32'd1);
    chk("lit_oow_err", 32'(data_err), 32'd1);
    chk("lit_oow_rdata", data_rdata, 32'd0);

    // Starvation guard: expected grant pattern IIIID IIIID.
    step(); instr_req = 1'b1; instr_addr = 32'h20; data_req = 1'b1; data_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      chk("lit_strk_igrant", 32'(instr_gnt), 32'((i % 5) != 4));
      chk("lit_strk_dgrant", 32'(data_gnt), 32'((i % 5) == 4));
      if (i == 5) chk("lit_strk_clear", 32'(dut.streak_q), 32'd0);
    end
    step(); instr_req = 1'b0; data_req = 1'b0;

    // Reset in the cycle after a data grant discards the response.
    step(); data_req = 1'b1; data_addr = 32'h44;
    @(negedge clk_sys);
    chk("lit_mid_gnt", 32'(data_gnt), 32'd1);
    step(); rst_sys_n = 1'b0; data_req = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      chk("lit_mid_rvalid_rst", 32'(data_rvalid), 32'd0);
    end
    step(); rst_sys_n = 1'b1;
    repeat (2) begin
      @(negedge clk_sys);
      chk("lit_mid_rvalid_rel", 32'(data_rvalid), 32'd0);
      chk("lit_mid_streak", 32'(dut.streak_q), 32'd0);
    end

    // Randomized traffic; requesters hold req/addr until granted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      ig = instr_gnt;
      dg = data_gnt;
      step();
      if (c % 700 == 350) rst_sys_n = 1'b0;
      if (c % 700 == 352) rst_sys_n = 1'b1;
      if (!instr_req || ig) begin
        instr_req  = ($urandom_range(0, 3) != 0);
        instr_addr = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(1, 65535)) << 16)
                                                 : (32'($urandom_range(0, 63)) << 2);
      end
      if (!data_req || dg) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_we    = $urandom_range(0, 1) != 0;
        data_be    = 4'($urandom_range(0, 15));
        data_wdata = $urandom();
        data_addr  = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(1, 65535)) << 16)
                                                 : (32'($urandom_range(0, 63)) << 2);
      end
    end
    step(); instr_req = 1'b0; data_req = 1'b0;
    repeat (3) @(negedge clk_sys);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
